// File: rtl/bin2ascii_tx_pkg.sv
// Shared types and constants for the binary-to-ASCII digit transmitter.
package bin2ascii_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;
    localparam int CNT_W      = $clog2(BIN_W);

    // idx: 2 = hundreds, 1 = tens, 0 = units
    function automatic logic [3:0] pick_digit(input logic [BCD_DIGITS-1:0][3:0] b,
                                              input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd2:    nib = b[2];
            2'd1:    nib = b[1];
            default: nib = b[0];
        endcase
        return nib;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return ASCII_ZERO + {4'd0, nib};
    endfunction

endpackage

// File: rtl/bin2ascii_tx_if.sv
// Input value channel and output character channel, each a valid/ready pair.
interface bin2ascii_tx_if;
    import bin2ascii_tx_pkg::*;

    logic [BIN_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );

endinterface

// File: rtl/bin2ascii_tx_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Input never exceeds 9, so the 4-bit sum cannot overflow.
    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2ascii_tx.sv
// Converts an 8-bit value to three BCD digits and streams them as ASCII plus a terminator.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (units always sent).
module bin2ascii_tx
    import bin2ascii_tx_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = ASCII_COLON
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2ascii_tx_if.slave  bus
);

    state_t                         state;
    logic [BIN_W-1:0]               bin, bin_next;
    logic [BCD_DIGITS-1:0][3:0]     bcd, bcd_adj, bcd_next;
    logic [CNT_W-1:0]               cnt;
    logic [1:0]                     dig, start_dig;
    logic                           in_ready_q, out_valid_q, busy_q;
    logic [7:0]                     out_data_q;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (.d(bcd[g]), .q(bcd_adj[g]));
    end

    always_comb begin
        {bcd_next, bin_next} = {bcd_adj, bin} << 1;
    end

    // First digit to emit, taken from the value the last CONV shift produces.
    always_comb begin
        start_dig = 2'd2;
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_next[2] == 4'd0)
            start_dig = (bcd_next[1] == 4'd0) ? 2'd0 : 2'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            dig         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        bin        <= bus.in_data;
                        bcd        <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    bcd <= bcd_next;
                    bin <= bin_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        dig         <= start_dig;
                        out_valid_q <= 1'b1;
                        out_data_q  <= to_ascii(pick_digit(bcd_next, start_dig));
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (dig == 2'd0) begin
                            out_data_q <= TERM_CHAR;
                            state      <= TERM;
                        end else begin
                            dig        <= dig - 2'd1;
                            out_data_q <= to_ascii(pick_digit(bcd, dig - 2'd1));
                        end
                    end
                end
                TERM: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule
